// File: rtl/cba_drv_pkg.sv
// Shared types and widths for the CoreCBA column-base driver.
// Width constants mirror the chip-level CBA row/data/latency defines.
package cba_drv_pkg;

  localparam int unsigned CbaRowBits       = 9;
  localparam int unsigned CbaDataBits      = 16;
  localparam int unsigned CbaSgLatencyBits = 9;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StSelect,
    StRelease
  } drv_state_e;

  // Phase counter must hold the longest phase length minus one, plus a spare bit.
  function automatic int unsigned phase_cnt_w(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cba_az_gen.sv
// Auto-zero (PhiAz) generator: periodic pulse from a free counter plus a one-shot trigger.
module cba_az_gen
  import cba_drv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        az_enable_i,
  input  logic [15:0] az_period_i,
  input  logic [7:0]  az_width_i,
  input  logic        az_trig_i,
  output logic        phi_az_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        run_q;
  logic [7:0]  trig_rem_q, trig_rem_d;
  logic        phi_q, phi_d;
  logic        run;
  logic [15:0] lim;
  logic [15:0] width_ext;

  always_comb begin
    run       = az_enable_i && (az_period_i >= 16'd2) && (az_width_i != 8'd0);
    width_ext = {8'd0, az_width_i};
    lim       = (width_ext < (az_period_i - 16'd1)) ? width_ext : (az_period_i - 16'd1);

    // Counter restarts at zero on the first running cycle and is parked at zero otherwise.
    cnt_d = '0;
    if (run && run_q) begin
      cnt_d = (cnt_q >= (az_period_i - 16'd1)) ? 16'd0 : (cnt_q + 16'd1);
    end

    trig_rem_d = trig_rem_q;
    if (az_trig_i && !phi_q) begin
      trig_rem_d = (az_width_i == 8'd0) ? 8'd1 : az_width_i;
    end else if (trig_rem_q != 8'd0) begin
      trig_rem_d = trig_rem_q - 8'd1;
    end

    phi_d = (run && (cnt_d < lim)) || (trig_rem_d != 8'd0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      run_q      <= 1'b0;
      trig_rem_q <= '0;
      phi_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_q      <= run;
      trig_rem_q <= trig_rem_d;
      phi_q      <= phi_d;
    end
  end

  assign phi_az_o = phi_q;

endmodule

// File: rtl/core_cba_driver.sv
// Column-base driver for the CoreCBA daisy chain: config write sequencer, static config
// registers, readback capture and auto-zero generator; all chain-head outputs are registered.
module core_cba_driver
  import cba_drv_pkg::*;
#(
  parameter int unsigned RowW     = CbaRowBits,
  parameter int unsigned DataW    = CbaDataBits,
  parameter int unsigned LatW     = CbaSgLatencyBits,
  parameter int unsigned SetupCyc = 4,
  parameter int unsigned HoldCyc  = 4,
  parameter int unsigned RelCyc   = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [RowW-1:0]  wr_row_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic             wr_err_o,
  output logic             busy_o,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             cfg_sel_c2f_i,
  input  logic             cfg_sel_c4f_i,
  input  logic             cfg_fast_en_i,
  input  logic [LatW-1:0]  cfg_sync_time_i,
  input  logic             az_enable_i,
  input  logic [15:0]      az_period_i,
  input  logic [7:0]       az_width_i,
  input  logic             az_trig_i,
  output logic [RowW-1:0]  cba_row_in_o,
  output logic [DataW-1:0] cba_data_in_o,
  output logic             cba_phi_az_in_o,
  output logic             cba_sel_c2f_in_o,
  output logic             cba_sel_c4f_in_o,
  output logic             cba_fast_en_in_o,
  output logic [LatW-1:0]  cba_write_sync_time_in_o,
  input  logic [DataW-1:0] cba_data_out_i
);

  localparam int unsigned PhaseW = phase_cnt_w(SetupCyc, HoldCyc, RelCyc);
  localparam logic [PhaseW-1:0] SetupLast = PhaseW'(SetupCyc - 1);
  localparam logic [PhaseW-1:0] HoldLast  = PhaseW'(HoldCyc - 1);
  localparam logic [PhaseW-1:0] RelLast   = PhaseW'(RelCyc - 1);

  drv_state_e        state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [RowW-1:0]   row_lat_q, row_lat_d;
  logic [RowW-1:0]   row_in_q, row_in_d;
  logic [DataW-1:0]  data_in_q, data_in_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DataW-1:0]  rd_data_q, rd_data_d;
  logic              sel_c2f_q, sel_c2f_d;
  logic              sel_c4f_q, sel_c4f_d;
  logic              fast_en_q, fast_en_d;
  logic [LatW-1:0]   sync_time_q, sync_time_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 1'b1;
    row_lat_d   = row_lat_q;
    row_in_d    = row_in_q;
    data_in_d   = data_in_q;
    wr_err_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    sel_c2f_d   = sel_c2f_q;
    sel_c4f_d   = sel_c4f_q;
    fast_en_d   = fast_en_q;
    sync_time_d = sync_time_q;

    unique case (state_q)
      StIdle: begin
        phase_d     = '0;
        // Static config only follows its inputs between writes.
        sel_c2f_d   = cfg_sel_c2f_i;
        sel_c4f_d   = cfg_sel_c4f_i;
        fast_en_d   = cfg_fast_en_i;
        sync_time_d = cfg_sync_time_i;
        if (wr_valid_i) begin
          if (wr_row_i == '0) begin
            wr_err_d = 1'b1;
          end else begin
            state_d   = StSetup;
            data_in_d = wr_data_i;
            row_lat_d = wr_row_i;
            row_in_d  = '0;
          end
        end
      end
      StSetup: begin
        if (phase_q == SetupLast) begin
          state_d  = StSelect;
          phase_d  = '0;
          row_in_d = row_lat_q;
        end
      end
      StSelect: begin
        if (phase_q == HoldLast) begin
          state_d  = StRelease;
          phase_d  = '0;
          row_in_d = '0;
        end
      end
      StRelease: begin
        if (phase_q == RelLast) begin
          state_d    = StIdle;
          phase_d    = '0;
          rd_data_d  = cba_data_out_i;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        phase_d  = '0;
        row_in_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      row_lat_q   <= '0;
      row_in_q    <= '0;
      data_in_q   <= '0;
      wr_err_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      sel_c2f_q   <= 1'b0;
      sel_c4f_q   <= 1'b0;
      fast_en_q   <= 1'b0;
      sync_time_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      row_lat_q   <= row_lat_d;
      row_in_q    <= row_in_d;
      data_in_q   <= data_in_d;
      wr_err_q    <= wr_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      sel_c2f_q   <= sel_c2f_d;
      sel_c4f_q   <= sel_c4f_d;
      fast_en_q   <= fast_en_d;
      sync_time_q <= sync_time_d;
    end
  end

  cba_az_gen u_az_gen (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .az_enable_i (az_enable_i),
    .az_period_i (az_period_i),
    .az_width_i  (az_width_i),
    .az_trig_i   (az_trig_i),
    .phi_az_o    (cba_phi_az_in_o)
  );

  assign wr_ready_o               = (state_q == StIdle);
  assign busy_o                   = (state_q != StIdle);
  assign wr_err_o                 = wr_err_q;
  assign rd_valid_o               = rd_valid_q;
  assign rd_data_o                = rd_data_q;
  assign cba_row_in_o             = row_in_q;
  assign cba_data_in_o            = data_in_q;
  assign cba_sel_c2f_in_o         = sel_c2f_q;
  assign cba_sel_c4f_in_o         = sel_c4f_q;
  assign cba_fast_en_in_o         = fast_en_q;
  assign cba_write_sync_time_in_o = sync_time_q;

endmodule
